// File: rtl/leaf_interface_pkg.sv
// leaf_interface_pkg: shared constants and bus-field helpers for the BFT leaf adapter.
// Bus layout is {valid, dest_addr, payload}; the helpers give field positions
// from the bus width and payload width so no block hard-codes offsets.
package leaf_interface_pkg;

    localparam int unsigned drop_cnt_w = 16;

    // Index of the valid tag (bus MSB).
    function automatic int unsigned bus_valid_idx(input int unsigned bus_w);
        return bus_w - 1;
    endfunction

    // Upper bound of the destination-address slice.
    function automatic int unsigned bus_addr_hi(input int unsigned bus_w);
        return bus_w - 2;
    endfunction

    // Lower bound of the destination-address slice.
    function automatic int unsigned bus_addr_lo(input int unsigned pl_w);
        return pl_w;
    endfunction

    // FIFO pointer width: one extra MSB distinguishes full from empty.
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/leaf_fifo.sv
// leaf_fifo: synchronous FIFO, first-word fall-through read, async active-high reset.
// Ports:
//   clk, reset      clock / asynchronous active-high reset
//   push, wdata     write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   rdata           head entry, valid while empty=0
//   full, empty     occupancy flags decoded from the pointers
module leaf_fifo
    import leaf_interface_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned aw = $clog2(depth);
    localparam int unsigned pw = fifo_ptr_w(depth);

    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic [width-1:0] mem [depth];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr[aw-1:0]];

    // Pointer update; wrap is natural modulo 2*depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + pw'(1);
            if (do_pop)  rd_ptr <= rd_ptr + pw'(1);
        end
    end

    // Storage; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[aw-1:0]] <= wdata;
    end

endmodule

// File: rtl/leaf_interface.sv
// leaf_interface: PE <-> BFT leaf adapter below the level-0 pi_switch.
// TX FIFO buffers PE packets and injects one per cycle onto bus_o as {1, dest, payload}.
// RX FIFO captures packets for this leaf from bus_i; the tree cannot be stalled, so
// misrouted packets and packets arriving at a full, non-draining FIFO are dropped.
// Optional feature macro: LEAF_DROP_CNT_EN adds a saturating 16-bit drop_cnt port.
// Ports:
//   clk, reset                       clock / asynchronous active-high reset
//   in_valid, in_ready, in_data      PE -> tree stream ({dest, payload})
//   out_valid, out_ready, out_data   tree -> PE stream (FWFT head of RX FIFO)
//   bus_o                            registered packet to the switch leaf input
//   bus_i                            packet from the switch leaf output
//   rx_drop                          one-cycle pulse per discarded arrival
//   drop_cnt                         saturating drop count (LEAF_DROP_CNT_EN only)
module leaf_interface
    import leaf_interface_pkg::*;
#(
    parameter int unsigned num_leaves = 2,
    parameter int unsigned payload_sz = 1,
    parameter int unsigned addr       = 0,
    parameter int unsigned p_sz       = 1 + $clog2(num_leaves) + payload_sz,
    parameter int unsigned fifo_depth = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [p_sz-2:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [p_sz-2:0] out_data,
    output logic [p_sz-1:0] bus_o,
    input  logic [p_sz-1:0] bus_i,
    output logic            rx_drop
`ifdef LEAF_DROP_CNT_EN
    ,
    output logic [drop_cnt_w-1:0] drop_cnt
`endif
);

    localparam int unsigned aw        = $clog2(num_leaves);
    localparam int unsigned dw        = p_sz - 1;
    localparam int unsigned valid_idx = bus_valid_idx(p_sz);
    localparam int unsigned addr_hi   = bus_addr_hi(p_sz);
    localparam int unsigned addr_lo   = bus_addr_lo(payload_sz);

    logic          tx_full;
    logic          tx_empty;
    logic          tx_push;
    logic          tx_pop;
    logic [dw-1:0] tx_head;

    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_pop;
    logic          pkt_valid;
    logic          dest_match;
    logic          drop_now;

    // ---------------- TX path ----------------
    // Gated by reset so the PE sees no acceptance while state is being cleared.
    assign in_ready = !tx_full && !reset;
    assign tx_push  = in_valid && in_ready;
    // The tree always accepts a leaf input, so drain every non-empty cycle.
    assign tx_pop   = !tx_empty;

    leaf_fifo #(
        .width (dw),
        .depth (fifo_depth)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (in_data),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Injection register; no combinational path from bus_i.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_o <= '0;
        end else if (tx_pop) begin
            bus_o <= {1'b1, tx_head};
        end else begin
            bus_o <= '0;
        end
    end

    // ---------------- RX path ----------------
    assign out_valid  = !rx_empty;
    assign rx_pop     = out_valid && out_ready;
    assign pkt_valid  = bus_i[valid_idx];
    assign dest_match = (bus_i[addr_hi:addr_lo] == aw'(addr));
    // When full, out_valid is 1, so out_ready implies a pop that frees the slot.
    assign rx_push    = pkt_valid && dest_match && (!rx_full || out_ready);
    assign drop_now   = pkt_valid && !rx_push;

    leaf_fifo #(
        .width (dw),
        .depth (fifo_depth)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (bus_i[dw-1:0]),
        .rdata (out_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Drop pulse, visible for the cycle after the decision edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_drop <= 1'b0;
        end else begin
            rx_drop <= drop_now;
        end
    end

`ifdef LEAF_DROP_CNT_EN
    // Saturating drop counter, updated on the same edge as rx_drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_now && (drop_cnt != {drop_cnt_w{1'b1}})) begin
            drop_cnt <= drop_cnt + drop_cnt_w'(1);
        end
    end
`endif

endmodule

// File: tb/tb_leaf_interface.sv
// tb_leaf_interface: directed + randomized bench for leaf_interface against a
// queue-based reference model (num_leaves=4, payload_sz=8, addr=2, fifo_depth=4).
module tb_leaf_interface;

    localparam int unsigned NL    = 4;
    localparam int unsigned PL    = 8;
    localparam int unsigned ADDR  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PSZ   = 11;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [PSZ-2:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [PSZ-2:0] out_data;
    logic [PSZ-1:0] bus_o;
    logic [PSZ-1:0] bus_i;
    logic           rx_drop;
`ifdef LEAF_DROP_CNT_EN
    logic [15:0]    drop_cnt;
    int unsigned    exp_cnt;
`endif

    logic [PSZ-2:0] tx_q[$];
    logic [PSZ-2:0] rx_q[$];
    int             passes = 0;
    int             total  = 0;

    leaf_interface #(
        .num_leaves (NL),
        .payload_sz (PL),
        .addr       (ADDR),
        .p_sz       (PSZ),
        .fifo_depth (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .bus_o     (bus_o),
        .bus_i     (bus_i),
        .rx_drop   (rx_drop)
`ifdef LEAF_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [PSZ-1:0] rx_pkt(input logic [1:0] dest, input logic [7:0] pl);
        return {1'b1, dest, pl};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one clock: predict from current inputs, clock, then compare.
    task automatic step();
        logic [PSZ-1:0] exp_bus;
        logic           exp_drop;
        logic           tx_accept;
        logic           rx_was_full;
        tx_accept   = in_valid && (tx_q.size() < DEPTH);
        rx_was_full = (rx_q.size() == DEPTH);
        // TX: head leaves on this edge, new packet joins behind it
        if (tx_q.size() > 0) exp_bus = {1'b1, tx_q.pop_front()};
        else                 exp_bus = '0;
        if (tx_accept) tx_q.push_back(in_data);
        // RX: drop rules, then pop before push
        exp_drop = 1'b0;
        if (out_ready && rx_q.size() > 0) void'(rx_q.pop_front());
        if (bus_i[PSZ-1]) begin
            if (int'(bus_i[PSZ-2:PL]) != ADDR)  exp_drop = 1'b1;
            else if (rx_was_full && !out_ready) exp_drop = 1'b1;
            else                                rx_q.push_back(bus_i[PSZ-2:0]);
        end
`ifdef LEAF_DROP_CNT_EN
        if (exp_drop && exp_cnt < 32'hFFFF) exp_cnt++;
`endif
        @(posedge clk);
        #1;
        check("bus_o", 16'(bus_o), 16'(exp_bus));
        check("rx_drop", 16'(rx_drop), 16'(exp_drop));
        check("out_valid", 16'(out_valid), 16'(rx_q.size() > 0));
        check("in_ready", 16'(in_ready), 16'(tx_q.size() < DEPTH));
        if (rx_q.size() > 0) check("out_data", 16'(out_data), 16'(rx_q[0]));
`ifdef LEAF_DROP_CNT_EN
        check("drop_cnt", drop_cnt, 16'(exp_cnt));
`endif
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        bus_i     = '0;
`ifdef LEAF_DROP_CNT_EN
        exp_cnt   = 0;
`endif
        #2;
        // reset state
        check("rst_in_ready", 16'(in_ready), 16'h0);
        check("rst_bus_o", 16'(bus_o), 16'h0);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_rx_drop", 16'(rx_drop), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rel_in_ready", 16'(in_ready), 16'h1);

        // TX fill: 5 back-to-back packets
        in_valid = 1'b1;
        in_data  = 10'h2A5;
        step();
        in_data = 10'($urandom);
        step();
        check("tx_example", 16'(bus_o), 16'h6A5);
        for (int i = 0; i < 3; i++) begin
            in_data = 10'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("tx_drained", 16'(bus_o), 16'h0);

        // RX overflow with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_i = rx_pkt(2'd2, 8'($urandom));
            step();
        end
        check("ovf_drop", 16'(rx_drop), 16'h1);
`ifdef LEAF_DROP_CNT_EN
        check("ovf_cnt", drop_cnt, 16'h1);
`endif
        bus_i = '0;
        step();
        check("ovf_drop_end", 16'(rx_drop), 16'h0);

        // Full with simultaneous pop, 12 packets across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus_i = rx_pkt(2'd2, 8'($urandom));
            step();
            check("full_pop_nodrop", 16'(rx_drop), 16'h0);
        end
        bus_i = '0;
        for (int i = 0; i < 5; i++) step();
        check("full_pop_empty", 16'(out_valid), 16'h0);

        // Misrouted packet
        out_ready = 1'b0;
        bus_i = rx_pkt(2'd1, 8'($urandom));
        step();
        check("misroute_drop", 16'(rx_drop), 16'h1);
        check("misroute_empty", 16'(out_valid), 16'h0);
        bus_i = '0;
        step();

        // Randomized traffic: first congested, then mostly draining
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 10'($urandom);
            out_ready = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 3)      bus_i = '0;
            else if (r < 9) bus_i = rx_pkt(2'd2, 8'($urandom));
            else            bus_i = rx_pkt(2'($urandom), 8'($urandom));
            step();
        end

        // Reset mid-traffic: TX busy, RX holding 2, drop pulse active
        out_ready = 1'b0;
        in_valid  = 1'b1;
        bus_i     = '0;
        for (int i = 0; i < 6; i++) step();
        out_ready = 1'b1;
        step();
        step();
        step();
        step();
        step();
        out_ready = 1'b0;
        in_data = 10'h155;
        bus_i = rx_pkt(2'd2, 8'h11);
        step();
        bus_i = rx_pkt(2'd2, 8'h22);
        step();
        bus_i = rx_pkt(2'd3, 8'h33);
        step();
        check("pre_rst_out_valid", 16'(out_valid), 16'h1);
        check("pre_rst_rx_drop", 16'(rx_drop), 16'h1);
        in_valid = 1'b0;
        bus_i    = '0;
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_bus_o", 16'(bus_o), 16'h0);
        check("mid_rst_out_valid", 16'(out_valid), 16'h0);
        check("mid_rst_rx_drop", 16'(rx_drop), 16'h0);
        check("mid_rst_in_ready", 16'(in_ready), 16'h0);
        tx_q.delete();
        rx_q.delete();
`ifdef LEAF_DROP_CNT_EN
        exp_cnt = 0;
        check("mid_rst_cnt", drop_cnt, 16'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("post_rst_bus_o", 16'(bus_o), 16'h0);

`ifdef LEAF_DROP_CNT_EN
        // Counter saturation via 65537 misrouted drops, then hold
        bus_i = rx_pkt(2'd0, 8'h5A);
        for (int i = 0; i < 65537; i++) step();
        check("sat_cnt", drop_cnt, 16'hFFFF);
        step();
        step();
        check("sat_hold", drop_cnt, 16'hFFFF);
        bus_i = '0;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
